timer_periph: RTL and testbench

Memory-mapped countdown/interval timer peripheral, the responder side of the CPU's `TIMER_ctrl` / `TIMER_done` register pair in `Top`. The CPU writes a limit and mode to the control register. The block counts prescaled ticks and raises a sticky `done` flag the CPU polls through `TIMER_done_rdata`. It sits on the 10 MHz core clock domain beside the sensor and display peripherals.

---
 rtl/timer_periph_if.sv | 24 ++
 rtl/timer_periph.sv | 114 +++++++++++
 tb/tb_timer_periph.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/timer_periph_if.sv
// Register-bus bundle between the CPU and the timer peripheral: the
// control-register write port, the status-register write-1-to-clear port,
// the read-data paths and the interrupt line.
interface timer_periph_if;
    logic        ctrl_we;
    logic [31:0] ctrl_wdata;
    logic        done_we;
    logic [31:0] done_wdata;
    logic [31:0] done_rdata;
    logic [31:0] cnt_rdata;
    logic        irq;

    // CPU side: issues register writes, reads status and count.
    modport master (
        output ctrl_we, ctrl_wdata, done_we, done_wdata,
        input  done_rdata, cnt_rdata, irq
    );

    // Peripheral side: accepts register writes, returns status and count.
    modport slave (
        input  ctrl_we, ctrl_wdata, done_we, done_wdata,
        output done_rdata, cnt_rdata, irq
    );
endinterface

// File: rtl/timer_periph.sv
// Countdown/interval timer peripheral. Counts prescaled ticks up to a
// programmed limit, raises a sticky done flag (and irq), and in periodic
// mode flags an overflow when an expiry lands on a still-set done flag.
module timer_periph #(
    parameter bit Simulacion = 1'b0,
    parameter int CLK_HZ     = 10_000_000,
    parameter int TICK_HZ    = 1_000
) (
    input  logic           clk,
    input  logic           reset,
    timer_periph_if.slave  bus
);
    localparam int DIV   = Simulacion ? 1 : (CLK_HZ / TICK_HZ);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    logic [30:0]       limit_r;
    logic              periodic_r;
    logic [30:0]       cnt_r;
    logic [PRE_W-1:0]  pre_r;
    logic              done_r;
    logic              ovf_r;

    logic              busy_s;
    logic              tick_s;
    logic              expire_s;
    logic              unused_s;

    // Tick and expiry qualifiers derived from the current register state.
    always_comb begin
        busy_s   = (state_r == ST_RUN);
        tick_s   = busy_s && (pre_r == PRE_LAST);
        expire_s = tick_s && ((cnt_r + 31'd1) == limit_r);
    end

    // Timer FSM with prescaler, tick counter and sticky status flags.
    // Flag clears are written before the expiry logic so a same-edge
    // expiry overrides the clear (set wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            limit_r    <= 31'd0;
            periodic_r <= 1'b0;
            cnt_r      <= 31'd0;
            pre_r      <= {PRE_W{1'b0}};
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (bus.ctrl_we) begin
            limit_r    <= bus.ctrl_wdata[30:0];
            periodic_r <= bus.ctrl_wdata[31];
            cnt_r      <= 31'd0;
            pre_r      <= {PRE_W{1'b0}};
            ovf_r      <= 1'b0;
            if (bus.ctrl_wdata[30:0] == 31'd0) begin
                // Zero limit expires immediately without ever running.
                state_r <= ST_IDLE;
                done_r  <= 1'b1;
            end else begin
                state_r <= ST_RUN;
                done_r  <= 1'b0;
            end
        end else begin
            if (bus.done_we && bus.done_wdata[0]) begin
                done_r <= 1'b0;
            end
            if (bus.done_we && bus.done_wdata[2]) begin
                ovf_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (tick_s) begin
                        pre_r <= {PRE_W{1'b0}};
                        if (expire_s) begin
                            done_r <= 1'b1;
                            if (done_r && periodic_r) begin
                                ovf_r <= 1'b1;
                            end
                            if (periodic_r) begin
                                cnt_r <= 31'd0;
                            end else begin
                                cnt_r   <= limit_r;
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + 31'd1;
                        end
                    end else begin
                        pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data and interrupt are driven straight from registers.
    assign bus.done_rdata = {29'd0, ovf_r, busy_s, done_r};
    assign bus.cnt_rdata  = {1'b0, cnt_r};
    assign bus.irq        = done_r;

    // Status write bits with no function.
    assign unused_s = ^{bus.done_wdata[31:3], bus.done_wdata[1]};
endmodule

// File: tb/tb_timer_periph.sv
// Directed bench for timer_periph: a fast instance (one tick per clock)
// and a prescaled instance (DIV = 10) share the clock and reset.
module tb_timer_periph;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    timer_periph_if bus_f ();
    timer_periph_if bus_s ();

    timer_periph #(.Simulacion(1'b1), .CLK_HZ(10_000_000), .TICK_HZ(1_000)) dut_f (
        .clk(clk), .reset(reset), .bus(bus_f)
    );
    timer_periph #(.Simulacion(1'b0), .CLK_HZ(100), .TICK_HZ(10)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_f.ctrl_we = 1'b0; bus_f.ctrl_wdata = 32'd0;
        bus_f.done_we = 1'b0; bus_f.done_wdata = 32'd0;
        bus_s.ctrl_we = 1'b0; bus_s.ctrl_wdata = 32'd0;
        bus_s.done_we = 1'b0; bus_s.done_wdata = 32'd0;

        // Reset for 10 cycles.
        for (int i = 0; i < 10; i++) step();
        chk("rst_done_f", bus_f.done_rdata, 32'h0);
        chk("rst_cnt_f",  bus_f.cnt_rdata,  32'h0);
        chk("rst_irq_f",  {31'd0, bus_f.irq}, 32'h0);
        chk("rst_done_s", bus_s.done_rdata, 32'h0);
        reset = 1'b0;
        step();

        // One-shot, limit 5.
        bus_f.ctrl_we = 1'b1; bus_f.ctrl_wdata = 32'h0000_0005;
        step();
        bus_f.ctrl_we = 1'b0;
        chk("os_busy_n0", bus_f.done_rdata, 32'h2);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("os_busy", bus_f.done_rdata, 32'h2);
            chk("os_cnt",  bus_f.cnt_rdata,  32'(i));
        end
        step();
        chk("os_done", bus_f.done_rdata, 32'h1);
        chk("os_irq",  {31'd0, bus_f.irq}, 32'h1);
        chk("os_cnt5", bus_f.cnt_rdata, 32'd5);
        for (int i = 0; i < 3; i++) step();
        chk("os_hold_cnt",  bus_f.cnt_rdata,  32'd5);
        chk("os_hold_done", bus_f.done_rdata, 32'h1);

        // Write-1-to-clear done.
        bus_f.done_we = 1'b1; bus_f.done_wdata = 32'h1;
        step();
        bus_f.done_we = 1'b0;
        chk("clr_done", bus_f.done_rdata, 32'h0);
        chk("clr_irq",  {31'd0, bus_f.irq}, 32'h0);

        // Limit 0: immediate done, never busy.
        bus_f.ctrl_we = 1'b1; bus_f.ctrl_wdata = 32'h0;
        step();
        bus_f.ctrl_we = 1'b0;
        chk("lim0_done", bus_f.done_rdata, 32'h1);
        chk("lim0_cnt",  bus_f.cnt_rdata,  32'h0);
        step();
        chk("lim0_idle", bus_f.done_rdata, 32'h1);

        // Periodic, limit 3, no clears: done at N+3, ovf at N+6.
        bus_f.ctrl_we = 1'b1; bus_f.ctrl_wdata = 32'h8000_0003;
        step();
        bus_f.ctrl_we = 1'b0;
        chk("per_start", bus_f.done_rdata, 32'h2);
        step(); step();
        chk("per_n2",     bus_f.done_rdata, 32'h2);
        chk("per_n2_cnt", bus_f.cnt_rdata,  32'd2);
        step();
        chk("per_n3",     bus_f.done_rdata, 32'h3);
        chk("per_n3_cnt", bus_f.cnt_rdata,  32'd0);
        step(); step();
        chk("per_n5", bus_f.done_rdata, 32'h3);
        step();
        chk("per_ovf", bus_f.done_rdata, 32'h7);
        bus_f.done_we = 1'b1; bus_f.done_wdata = 32'h5;
        step();
        bus_f.done_we = 1'b0;
        chk("per_clr",     bus_f.done_rdata, 32'h2);
        chk("per_clr_cnt", bus_f.cnt_rdata,  32'd1);

        // Restart mid-run: limit 10, rewrite with limit 2 at N+4.
        bus_f.ctrl_we = 1'b1; bus_f.ctrl_wdata = 32'h0000_000A;
        step();
        bus_f.ctrl_we = 1'b0;
        step(); step(); step();
        chk("rs_cnt3", bus_f.cnt_rdata, 32'd3);
        bus_f.ctrl_we = 1'b1; bus_f.ctrl_wdata = 32'h0000_0002;
        step();
        bus_f.ctrl_we = 1'b0;
        chk("rs_cnt0", bus_f.cnt_rdata, 32'd0);
        step();
        chk("rs_n5", bus_f.done_rdata, 32'h2);
        step();
        chk("rs_n6", bus_f.done_rdata, 32'h1);

        // Set wins: clear done on the expiry edge.
        bus_f.ctrl_we = 1'b1; bus_f.ctrl_wdata = 32'h8000_0002;
        step();
        bus_f.ctrl_we = 1'b0;
        step();
        chk("sw_pre", bus_f.done_rdata, 32'h2);
        bus_f.done_we = 1'b1; bus_f.done_wdata = 32'h1;
        step();
        bus_f.done_we = 1'b0;
        chk("sw_done", bus_f.done_rdata, 32'h3);

        // ctrl_we beats done_we: limit 0 with a full clear.
        bus_f.ctrl_we = 1'b1; bus_f.ctrl_wdata = 32'h0;
        bus_f.done_we = 1'b1; bus_f.done_wdata = 32'h5;
        step();
        bus_f.ctrl_we = 1'b0; bus_f.done_we = 1'b0;
        chk("cw_wins", bus_f.done_rdata, 32'h1);

        // Prescaled instance, DIV = 10, limit 3: done exactly 30 cycles on.
        bus_s.ctrl_we = 1'b1; bus_s.ctrl_wdata = 32'h0000_0003;
        step();
        bus_s.ctrl_we = 1'b0;
        chk("ps_start", bus_s.done_rdata, 32'h2);
        for (int i = 0; i < 29; i++) step();
        chk("ps_n29",     bus_s.done_rdata, 32'h2);
        chk("ps_n29_cnt", bus_s.cnt_rdata,  32'd2);
        step();
        chk("ps_n30",     bus_s.done_rdata, 32'h1);
        chk("ps_n30_cnt", bus_s.cnt_rdata,  32'd3);

        // Second run, reset at cycle 15 discards the pending expiry.
        bus_s.ctrl_we = 1'b1; bus_s.ctrl_wdata = 32'h0000_0003;
        step();
        bus_s.ctrl_we = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("ps2_cnt", bus_s.cnt_rdata, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ps2_rst_done", bus_s.done_rdata, 32'h0);
        chk("ps2_rst_cnt",  bus_s.cnt_rdata,  32'h0);
        chk("ps2_rst_irq",  {31'd0, bus_s.irq}, 32'h0);
        for (int i = 0; i < 25; i++) begin
            step();
            chk("ps2_quiet", bus_s.done_rdata, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
